fetch: RTL and testbench
========================

# fetch

Instruction-fetch front end of the core: owns the program counter, issues one-word read requests to the instruction memory (fixed one-cycle read latency), and buffers returned instructions in a small FIFO toward decode using a valid/ready handshake. Handles control-flow redirects from execute by flushing buffered and in-flight instructions and restarting at the target. Sits between the branch/execute redirect path and the instruction memory on one side, and the decode stage on the other.

## Interface
- RESET_PC, default 32'h0000_0000: first fetch address after reset (byte address)
- FIFO_DEPTH, default 4: instruction buffer entries (power of two, ≥2)

- clk  in  1  core clock
- rstn  in  1  reset, asynchronous, active-low
- imem_readable  out  1  read request to instruction memory, registered
- imem_pc  out  32  byte address of request, registered
- imem_pc_in  in  32  address echoed by memory with its response
- imem_command  in  32  instruction word returned
- imem_command_ready  in  1  response valid, one cycle after a sampled request
- redirect_valid  in  1  flush and restart fetch
- redirect_pc  in  32  restart byte address (word aligned)
- if_valid  out  1  head instruction available to decode
- if_ready  in  1  decode accepts head this cycle
- if_pc  out  32  byte address of head instruction
- if_instr  out  32  head instruction word

## Operation
- Reset (asynchronous): imem_readable=0, imem_pc=RESET_PC, fetch_pc=RESET_PC, FIFO empty, in-flight=0, discard=0, if_valid=0, if_pc=0, if_instr=0.
- In-flight count (0..2): requests sampled by memory whose response is not yet written or dropped.
- Issue rule, evaluated at each edge for next cycle: imem_readable<=1, imem_pc<=fetch_pc, fetch_pc+=4 iff occupancy_next + inflight_next < FIFO_DEPTH and no redirect this cycle; otherwise imem_readable<=0. Guarantees no overflow; no response is ever refused.
- Response: imem_command_ready=1 and discard=0 → push {imem_pc_in, imem_command}; discard>0 → drop, discard-=1. imem_command_ready with in-flight=0 is ignored.
- Pop: if_valid && if_ready at edge removes head. Simultaneous push and pop allowed, including when full (push counted by credit, so full+push cannot occur without pop).
- if_pc/if_instr show head entry when if_valid=1, 0 when empty.
- Redirect (redirect_valid=1 at edge), highest priority: FIFO cleared (a coincident pop is void), discard<=in-flight count including any request presented this cycle, fetch_pc<=redirect_pc+4, imem_readable<=1, imem_pc<=redirect_pc. Back-to-back redirects: last one wins; discard accumulates correctly.
- PC arithmetic: 32-bit unsigned, wraps from 32'hFFFF_FFFC to 0.

## Timing
- Cycle N: imem_readable=1, imem_pc=P. Cycle N+1: memory drives command_ready=1, pc_out=P. Cycle N+2: entry visible; if_valid=1 if FIFO was empty.
- Fetch-to-decode latency 2 cycles; sustained throughput one instruction per cycle with if_ready held high.
- First request: cycle after rstn deassertion (imem_readable=1, imem_pc=RESET_PC); first if_valid two cycles later.
- Redirect at edge E: target request presented cycle E+1, target at if_valid in cycle E+3; no stale instruction ever visible after E.
- rstn assertion between edges clears all outputs immediately.

## Structure
- Shared package core_pkg: XLEN=32, ILEN=32, RESET_PC default, instruction-word and address typedefs.
- One sub-module: fetch_fifo (synchronous FIFO, depth FIFO_DEPTH, flush input, count output, async active-low reset). PC/credit/discard logic stays in fetch.

## Test plan
- Reset, RESET_PC=0, if_ready=1, memory model returns instr=addr^32'hA5A5_0000 → if_valid from cycle 3 after release, if_pc 0,4,8,… one per cycle, no gaps.
- if_ready=0 for 12 cycles → exactly 4 entries (pc 0..12) buffered, imem_readable low after credit exhausted; re-enable → pcs continue at 16, none lost or duplicated.
- Steady stream, redirect_pc=0x100 with 2 requests in flight → both responses dropped, next if_pc=0x100 at E+3, then 0x104.
- Redirect coincident with pop and with FIFO full → FIFO empty after edge, no stale entry, target appears at E+3.
- Redirects on consecutive cycles to 0x200 then 0x300 → first if_pc=0x300, nothing from 0x200 observed.
- rstn asserted mid-stream between edges → all outputs zero immediately; after release fetch restarts at RESET_PC; fetch_pc at 32'hFFFF_FFFC wraps to 0.

Source files
------------

// File: rtl/core_pkg.sv
// Core-wide widths, address/instruction types and the fetch buffer entry layout.
package core_pkg;

    localparam int XLEN = 32;
    localparam int ILEN = 32;

    typedef logic [XLEN-1:0] addr_t;
    typedef logic [ILEN-1:0] instr_t;

    localparam addr_t RESET_PC_DEFAULT = 32'h0000_0000;

    typedef struct packed {
        addr_t  pc;
        instr_t instr;
    } fetch_entry_t;

    // Sequential word address; wraps naturally at the top of the address space.
    function automatic addr_t next_pc(input addr_t pc);
        return pc + addr_t'(4);
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Instruction buffer between fetch and decode: synchronous FIFO with a flush
// that empties it in one edge and takes priority over push/pop.
module fetch_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head_data,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop, full;

    always_comb begin
        full     = (count_q == CNT_W'(DEPTH));
        do_pop   = pop && (count_q != '0) && !flush;
        // A push into a full buffer is only legal alongside a pop.
        do_push  = push && !flush && (!full || do_pop);
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

    assign head_data = mem_q[rd_ptr_q];
    assign empty     = (count_q == '0);
    assign count     = count_q;

endmodule

// File: rtl/fetch.sv
// Instruction fetch front end: PC ownership, credit-limited request issue to a
// one-cycle instruction memory, redirect flush/discard, and the decode-side buffer.
module fetch
    import core_pkg::*;
#(
    parameter addr_t RESET_PC   = RESET_PC_DEFAULT,
    parameter int    FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rstn,
    output logic        imem_readable,
    output logic [31:0] imem_pc,
    input  logic [31:0] imem_pc_in,
    input  logic [31:0] imem_command,
    input  logic        imem_command_ready,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W:0] CREDIT_MAX = (CNT_W + 1)'(FIFO_DEPTH);

    logic             imem_readable_q, imem_readable_d;
    addr_t            imem_pc_q, imem_pc_d;
    addr_t            fetch_pc_q, fetch_pc_d;
    logic [1:0]       inflight_q, inflight_d;
    logic [1:0]       discard_q, discard_d;

    logic             resp_take, push, pop, fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    logic [CNT_W:0]   occ_next, credit_used;
    fetch_entry_t     push_entry, head_entry;

    always_comb begin
        // Responses with nothing outstanding are spurious and ignored.
        resp_take  = imem_command_ready && (inflight_q != 2'd0);
        push       = resp_take && (discard_q == 2'd0) && !redirect_valid;
        pop        = !fifo_empty && if_ready && !redirect_valid;
        push_entry = '{pc: imem_pc_in, instr: imem_command};

        inflight_d  = inflight_q + 2'(imem_readable_q) - 2'(resp_take);
        occ_next    = {1'b0, fifo_count} + (CNT_W + 1)'(push) - (CNT_W + 1)'(pop);
        credit_used = occ_next + (CNT_W + 1)'(inflight_d);

        imem_readable_d = 1'b0;
        imem_pc_d       = imem_pc_q;
        fetch_pc_d      = fetch_pc_q;
        discard_d       = discard_q;

        if (redirect_valid) begin
            // Everything still outstanding after this edge belongs to the old path.
            discard_d       = inflight_d;
            imem_readable_d = 1'b1;
            imem_pc_d       = redirect_pc;
            fetch_pc_d      = next_pc(redirect_pc);
        end else begin
            if (resp_take && (discard_q != 2'd0)) discard_d = discard_q - 2'd1;
            if (credit_used < CREDIT_MAX) begin
                imem_readable_d = 1'b1;
                imem_pc_d       = fetch_pc_q;
                fetch_pc_d      = next_pc(fetch_pc_q);
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            imem_readable_q <= 1'b0;
            imem_pc_q       <= RESET_PC;
            fetch_pc_q      <= RESET_PC;
            inflight_q      <= 2'd0;
            discard_q       <= 2'd0;
        end else begin
            imem_readable_q <= imem_readable_d;
            imem_pc_q       <= imem_pc_d;
            fetch_pc_q      <= fetch_pc_d;
            inflight_q      <= inflight_d;
            discard_q       <= discard_d;
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(fetch_entry_t))
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rstn),
        .flush     (redirect_valid),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .head_data (head_entry),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign imem_readable = imem_readable_q;
    assign imem_pc       = imem_pc_q;
    assign if_valid      = !fifo_empty;
    assign if_pc         = fifo_empty ? 32'h0 : head_entry.pc;
    assign if_instr      = fifo_empty ? 32'h0 : head_entry.instr;

endmodule

// File: tb/tb_fetch.sv
// Scoreboard bench for fetch: a one-cycle memory model answers requests, expected
// head pcs are queued per scenario and popped as decode accepts instructions.
module tb_fetch;

    localparam logic [31:0] RST_PC = 32'h0;
    localparam logic [31:0] XORK   = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        rstn;
    logic        imem_readable;
    logic [31:0] imem_pc;
    logic [31:0] imem_pc_in;
    logic [31:0] imem_command;
    logic        imem_command_ready;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_pc;
    logic [31:0] if_instr;

    int checks = 0;
    int errors = 0;

    logic [31:0] sb[$];
    logic [31:0] mon_exp;

    bit          redir_at  [64];
    logic [31:0] redir_tgt [64];
    bit          stall_at  [64];
    logic        obs_v     [64];
    logic [31:0] obs_pc    [64];
    logic [31:0] obs_ins   [64];
    logic        obs_rd    [64];
    logic [31:0] obs_ipc   [64];

    fetch #(.RESET_PC(RST_PC), .FIFO_DEPTH(4)) dut (
        .clk                (clk),
        .rstn               (rstn),
        .imem_readable      (imem_readable),
        .imem_pc            (imem_pc),
        .imem_pc_in         (imem_pc_in),
        .imem_command       (imem_command),
        .imem_command_ready (imem_command_ready),
        .redirect_valid     (redirect_valid),
        .redirect_pc        (redirect_pc),
        .if_valid           (if_valid),
        .if_ready           (if_ready),
        .if_pc              (if_pc),
        .if_instr           (if_instr)
    );

    always #5 clk = ~clk;

    // Instruction memory: one-cycle latency, word = address ^ XORK.
    always @(posedge clk) begin
        if (!rstn) begin
            imem_command_ready <= 1'b0;
            imem_pc_in         <= 32'h0;
            imem_command       <= 32'h0;
        end else begin
            imem_command_ready <= imem_readable;
            imem_pc_in         <= imem_pc;
            imem_command       <= imem_pc ^ XORK;
        end
    end

    // Decode-side scoreboard: every accepted head must match the queue front.
    always @(negedge clk) begin
        if (rstn && if_valid && if_ready && !redirect_valid) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_extra: got pc %h instr %h, expected no instruction", if_pc, if_instr);
            end else begin
                mon_exp = sb.pop_front();
                if (if_pc !== mon_exp || if_instr !== (mon_exp ^ XORK)) begin
                    errors++;
                    $display("FAIL sb_order: got pc %h instr %h, expected pc %h instr %h",
                             if_pc, if_instr, mon_exp, mon_exp ^ XORK);
                end
            end
        end
    end

    task automatic do_reset();
        rstn           = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        if_ready       = 1'b0;
        sb.delete();
        for (int i = 0; i < 64; i++) begin
            redir_at[i]  = 1'b0;
            redir_tgt[i] = 32'h0;
            stall_at[i]  = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    // Entered just after an edge (edge 0); obs[k] holds state after edge k.
    task automatic run_cycles(input int n);
        for (int k = 1; k <= n; k++) begin
            redirect_valid = redir_at[k];
            redirect_pc    = redir_tgt[k];
            if_ready       = !stall_at[k] && (sb.size() != 0);
            @(posedge clk);
            #1;
            obs_v[k]   = if_valid;
            obs_pc[k]  = if_pc;
            obs_ins[k] = if_instr;
            obs_rd[k]  = imem_readable;
            obs_ipc[k] = imem_pc;
        end
        redirect_valid = 1'b0;
        if_ready       = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks += 5;
        if (imem_readable !== 1'b0) begin errors++; $display("FAIL rst_readable: got %b, expected 0", imem_readable); end
        if (imem_pc !== RST_PC)     begin errors++; $display("FAIL rst_imem_pc: got %h, expected %h", imem_pc, RST_PC); end
        if (if_valid !== 1'b0)      begin errors++; $display("FAIL rst_if_valid: got %b, expected 0", if_valid); end
        if (if_pc !== 32'h0)        begin errors++; $display("FAIL rst_if_pc: got %h, expected 0", if_pc); end
        if (if_instr !== 32'h0)     begin errors++; $display("FAIL rst_if_instr: got %h, expected 0", if_instr); end
    endtask

    task automatic test_stream();
        do_reset();
        for (int i = 0; i < 16; i++) sb.push_back(RST_PC + 32'(4 * i));
        rstn = 1'b1;
        run_cycles(24);
        checks += 3;
        if (obs_rd[1] !== 1'b1 || obs_ipc[1] !== RST_PC) begin
            errors++; $display("FAIL first_req: got rd %b pc %h, expected rd 1 pc %h", obs_rd[1], obs_ipc[1], RST_PC);
        end
        if (obs_v[1] !== 1'b0 || obs_v[2] !== 1'b0) begin
            errors++; $display("FAIL early_valid: got %b%b, expected 00", obs_v[1], obs_v[2]);
        end
        if (obs_pc[3] !== RST_PC) begin
            errors++; $display("FAIL first_if_pc: got %h, expected %h", obs_pc[3], RST_PC);
        end
        for (int k = 3; k <= 18; k++) begin
            checks++;
            if (obs_v[k] !== 1'b1) begin errors++; $display("FAIL stream_gap k=%0d: got %b, expected 1", k, obs_v[k]); end
        end
        checks++;
        if (sb.size() != 0) begin errors++; $display("FAIL stream_drain: got %0d left, expected 0", sb.size()); end
    endtask

    task automatic test_backpressure();
        int n_req;
        do_reset();
        for (int k = 1; k <= 12; k++) stall_at[k] = 1'b1;
        for (int i = 0; i < 12; i++) sb.push_back(RST_PC + 32'(4 * i));
        rstn = 1'b1;
        run_cycles(40);
        n_req = 0;
        for (int k = 1; k <= 12; k++) n_req += int'(obs_rd[k]);
        checks += 4;
        if (n_req != 4) begin errors++; $display("FAIL bp_requests: got %0d, expected 4", n_req); end
        if (obs_rd[12] !== 1'b0) begin errors++; $display("FAIL bp_credit: got readable %b, expected 0", obs_rd[12]); end
        if (obs_v[12] !== 1'b1 || obs_pc[12] !== RST_PC) begin
            errors++; $display("FAIL bp_head: got v %b pc %h, expected v 1 pc %h", obs_v[12], obs_pc[12], RST_PC);
        end
        if (sb.size() != 0) begin errors++; $display("FAIL bp_drain: got %0d left, expected 0", sb.size()); end
    endtask

    task automatic test_redirect_stream();
        do_reset();
        redir_at[10]  = 1'b1;
        redir_tgt[10] = 32'h100;
        for (int i = 0; i < 6; i++) sb.push_back(RST_PC + 32'(4 * i));
        for (int i = 0; i < 8; i++) sb.push_back(32'h100 + 32'(4 * i));
        rstn = 1'b1;
        run_cycles(36);
        checks += 4;
        if (obs_rd[10] !== 1'b1 || obs_ipc[10] !== 32'h100) begin
            errors++; $display("FAIL rd_req: got rd %b pc %h, expected rd 1 pc 00000100", obs_rd[10], obs_ipc[10]);
        end
        if (obs_v[10] !== 1'b0 || obs_v[11] !== 1'b0) begin
            errors++; $display("FAIL rd_flush: got %b%b, expected 00", obs_v[10], obs_v[11]);
        end
        if (obs_v[12] !== 1'b1 || obs_pc[12] !== 32'h100 || obs_ins[12] !== (32'h100 ^ XORK)) begin
            errors++; $display("FAIL rd_target: got v %b pc %h instr %h, expected v 1 pc 00000100", obs_v[12], obs_pc[12], obs_ins[12]);
        end
        if (sb.size() != 0) begin errors++; $display("FAIL rd_drain: got %0d left, expected 0", sb.size()); end
    endtask

    task automatic test_redirect_full();
        do_reset();
        for (int k = 1; k <= 12; k++) stall_at[k] = 1'b1;
        redir_at[13]  = 1'b1;
        redir_tgt[13] = 32'h40;
        for (int i = 0; i < 8; i++) sb.push_back(32'h40 + 32'(4 * i));
        rstn = 1'b1;
        run_cycles(40);
        checks += 4;
        if (obs_v[12] !== 1'b1) begin errors++; $display("FAIL full_pre: got v %b, expected 1", obs_v[12]); end
        if (obs_v[13] !== 1'b0 || obs_v[14] !== 1'b0) begin
            errors++; $display("FAIL full_flush: got %b%b, expected 00", obs_v[13], obs_v[14]);
        end
        if (obs_v[15] !== 1'b1 || obs_pc[15] !== 32'h40) begin
            errors++; $display("FAIL full_target: got v %b pc %h, expected v 1 pc 00000040", obs_v[15], obs_pc[15]);
        end
        if (sb.size() != 0) begin errors++; $display("FAIL full_drain: got %0d left, expected 0", sb.size()); end
    endtask

    task automatic test_back_to_back_redirect();
        do_reset();
        redir_at[10] = 1'b1; redir_tgt[10] = 32'h200;
        redir_at[11] = 1'b1; redir_tgt[11] = 32'h300;
        for (int i = 0; i < 6; i++) sb.push_back(RST_PC + 32'(4 * i));
        for (int i = 0; i < 8; i++) sb.push_back(32'h300 + 32'(4 * i));
        rstn = 1'b1;
        run_cycles(40);
        checks += 4;
        if (obs_ipc[11] !== 32'h300) begin errors++; $display("FAIL b2b_req: got %h, expected 00000300", obs_ipc[11]); end
        if (obs_v[10] !== 1'b0 || obs_v[11] !== 1'b0 || obs_v[12] !== 1'b0) begin
            errors++; $display("FAIL b2b_flush: got %b%b%b, expected 000", obs_v[10], obs_v[11], obs_v[12]);
        end
        if (obs_v[13] !== 1'b1 || obs_pc[13] !== 32'h300) begin
            errors++; $display("FAIL b2b_target: got v %b pc %h, expected v 1 pc 00000300", obs_v[13], obs_pc[13]);
        end
        if (sb.size() != 0) begin errors++; $display("FAIL b2b_drain: got %0d left, expected 0", sb.size()); end
    endtask

    task automatic test_async_reset_wrap();
        do_reset();
        for (int i = 0; i < 16; i++) sb.push_back(RST_PC + 32'(4 * i));
        rstn = 1'b1;
        run_cycles(8);
        if_ready = 1'b1;
        #3;
        checks++;
        if (if_valid !== 1'b1) begin errors++; $display("FAIL ar_pre: got v %b, expected 1", if_valid); end
        rstn = 1'b0;
        #1;
        checks += 5;
        if (imem_readable !== 1'b0) begin errors++; $display("FAIL ar_readable: got %b, expected 0", imem_readable); end
        if (imem_pc !== RST_PC)     begin errors++; $display("FAIL ar_imem_pc: got %h, expected %h", imem_pc, RST_PC); end
        if (if_valid !== 1'b0)      begin errors++; $display("FAIL ar_if_valid: got %b, expected 0", if_valid); end
        if (if_pc !== 32'h0)        begin errors++; $display("FAIL ar_if_pc: got %h, expected 0", if_pc); end
        if (if_instr !== 32'h0)     begin errors++; $display("FAIL ar_if_instr: got %h, expected 0", if_instr); end
        do_reset();
        redir_at[10]  = 1'b1;
        redir_tgt[10] = 32'hFFFF_FFFC;
        for (int i = 0; i < 6; i++) sb.push_back(RST_PC + 32'(4 * i));
        sb.push_back(32'hFFFF_FFFC);
        for (int i = 0; i < 7; i++) sb.push_back(32'(4 * i));
        rstn = 1'b1;
        run_cycles(36);
        checks += 4;
        if (obs_rd[1] !== 1'b1 || obs_ipc[1] !== RST_PC) begin
            errors++; $display("FAIL ar_restart: got rd %b pc %h, expected rd 1 pc %h", obs_rd[1], obs_ipc[1], RST_PC);
        end
        if (obs_rd[11] !== 1'b1 || obs_ipc[11] !== 32'h0) begin
            errors++; $display("FAIL wrap_req: got rd %b pc %h, expected rd 1 pc 00000000", obs_rd[11], obs_ipc[11]);
        end
        if (obs_v[12] !== 1'b1 || obs_pc[12] !== 32'hFFFF_FFFC) begin
            errors++; $display("FAIL wrap_target: got v %b pc %h, expected v 1 pc fffffffc", obs_v[12], obs_pc[12]);
        end
        if (sb.size() != 0) begin errors++; $display("FAIL wrap_drain: got %0d left, expected 0", sb.size()); end
    endtask

    initial begin
        rstn = 1'b0;
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_stream();
        test_redirect_full();
        test_back_to_back_redirect();
        test_async_reset_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
